// File: rtl/sysid_pkg.sv
// Shared constants for the sys_id register map and the ROM scan FSM.
// Word offsets are converted to byte addresses with reg_addr().
package sysid_pkg;

  localparam logic [7:0] REG_VERSION  = 8'h00;
  localparam logic [7:0] REG_ID       = 8'h01;
  localparam logic [7:0] REG_SCRATCH  = 8'h02;
  localparam logic [7:0] REG_MAGIC    = 8'h03;
  localparam logic [7:0] REG_ROM_DATA = 8'h21;
  localparam logic [7:0] REG_ROM_ADDR = 8'h22;

  localparam logic [31:0] CORE_MAGIC = 32'h53594944;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MAGIC,
    ST_WR_ADDR,
    ST_RD_DATA,
    ST_PUSH,
    ST_ERR,
    ST_FIN
  } state_t;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [7:0] word);
    return base + {6'd0, word, 2'b00};
  endfunction

endpackage

// File: rtl/up_axi_master.sv
// Single-transaction AXI4-Lite master driven by an up-style request interface.
// Requests are one-cycle pulses; acks are the combinational B/R handshakes.
module up_axi_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_wreq,
  input  logic [15:0] up_waddr,
  input  logic [31:0] up_wdata,
  output logic        up_wack,
  output logic [1:0]  up_wresp,
  input  logic        up_rreq,
  input  logic [15:0] up_raddr,
  output logic        up_rack,
  output logic [31:0] up_rdata,
  output logic [1:0]  up_rresp,
  output logic        m_axi_awvalid,
  output logic [15:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  input  logic        m_axi_awready,
  output logic        m_axi_wvalid,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_bready,
  output logic        m_axi_arvalid,
  output logic [15:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  input  logic [1:0]  m_axi_rresp,
  input  logic [31:0] m_axi_rdata,
  output logic        m_axi_rready
);

  logic aw_done_reg;
  logic w_done_reg;
  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign aw_ok = aw_done_reg | aw_hs;
  assign w_ok  = w_done_reg | w_hs;

  assign up_wack  = m_axi_bvalid & m_axi_bready;
  assign up_wresp = m_axi_bresp;
  assign up_rack  = m_axi_rvalid & m_axi_rready;
  assign up_rdata = m_axi_rdata;
  assign up_rresp = m_axi_rresp;

  assign m_axi_awprot = 3'd0;
  assign m_axi_arprot = 3'd0;
  assign m_axi_wstrb  = 4'hf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      if (up_wreq) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        m_axi_awaddr  <= up_waddr;
        m_axi_wdata   <= up_wdata;
        aw_done_reg   <= 1'b0;
        w_done_reg    <= 1'b0;
      end else begin
        if (aw_hs) begin
          m_axi_awvalid <= 1'b0;
          aw_done_reg   <= 1'b1;
        end
        if (w_hs) begin
          m_axi_wvalid <= 1'b0;
          w_done_reg   <= 1'b1;
        end
        // B is only accepted once both address and data have been taken
        if (aw_ok && w_ok) begin
          aw_done_reg  <= 1'b0;
          w_done_reg   <= 1'b0;
          m_axi_bready <= 1'b1;
        end
      end
      if (up_wack) m_axi_bready <= 1'b0;

      if (up_rreq) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= up_raddr;
      end else if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b1;
      end
      if (up_rack) m_axi_rready <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_sysid_reader.sv
// Scans the sys_id ROM over AXI4-Lite: checks the magic word, then for each
// address writes ROM_ADDR, reads ROM_DATA and presents the word on a stream port.
module axi_sysid_reader
  import sysid_pkg::*;
#(
  parameter int          ROM_WIDTH     = 32,
  parameter int          ROM_ADDR_BITS = 6,
  parameter logic [15:0] BASE_ADDR     = 16'h0000
) (
  input  logic                     m_axi_aclk,
  input  logic                     m_axi_aresetn,
  input  logic                     start,
  input  logic                     pr_sel,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error_code,
  output logic                     rom_valid,
  input  logic                     rom_ready,
  output logic [ROM_WIDTH-1:0]     rom_data,
  output logic [ROM_ADDR_BITS-1:0] rom_index,
  output logic                     m_axi_awvalid,
  output logic [15:0]              m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  input  logic                     m_axi_awready,
  output logic                     m_axi_wvalid,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  input  logic                     m_axi_wready,
  input  logic                     m_axi_bvalid,
  input  logic [1:0]               m_axi_bresp,
  output logic                     m_axi_bready,
  output logic                     m_axi_arvalid,
  output logic [15:0]              m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  input  logic                     m_axi_arready,
  input  logic                     m_axi_rvalid,
  input  logic [1:0]               m_axi_rresp,
  input  logic [31:0]              m_axi_rdata,
  output logic                     m_axi_rready
);

  localparam logic [15:0] MAGIC_ADDR = reg_addr(BASE_ADDR, REG_MAGIC);
  localparam logic [15:0] DATA_ADDR  = reg_addr(BASE_ADDR, REG_ROM_DATA);
  localparam logic [15:0] ADDR_ADDR  = reg_addr(BASE_ADDR, REG_ROM_ADDR);
  localparam logic [ROM_ADDR_BITS-1:0] LAST_INDEX = '1;
  localparam logic [ROM_ADDR_BITS-1:0] ONE_INDEX  = ROM_ADDR_BITS'(1);

  state_t                   state_reg;
  logic [ROM_ADDR_BITS-1:0] index_reg;
  logic                     pr_sel_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic [1:0]               error_reg;
  logic                     rom_valid_reg;
  logic [ROM_WIDTH-1:0]     rom_data_reg;

  logic                     up_wreq;
  logic [31:0]              up_wdata;
  logic                     up_wack;
  logic [1:0]               up_wresp;
  logic                     up_rreq;
  logic [15:0]              up_raddr;
  logic                     up_rack;
  logic [31:0]              up_rdata;
  logic [1:0]               up_rresp;
  logic                     start_ok;
  logic                     stream_hs;
  logic                     magic_ok;
  logic [ROM_ADDR_BITS-1:0] wr_index;

  // Requests are decoded from the transition edge so AR/AW issue one cycle later
  assign start_ok  = (state_reg == ST_IDLE) && start;
  assign stream_hs = rom_valid_reg && rom_ready;
  assign magic_ok  = up_rack && (up_rresp == RESP_OKAY) && (up_rdata == CORE_MAGIC);
  assign wr_index  = (state_reg == ST_PUSH) ? index_reg + ONE_INDEX : index_reg;

  assign up_wreq  = ((state_reg == ST_RD_MAGIC) && magic_ok) ||
                    ((state_reg == ST_PUSH) && stream_hs && (index_reg != LAST_INDEX));
  assign up_wdata = {pr_sel_reg, {(31-ROM_ADDR_BITS){1'b0}}, wr_index};
  assign up_rreq  = start_ok ||
                    ((state_reg == ST_WR_ADDR) && up_wack && (up_wresp == RESP_OKAY));
  assign up_raddr = start_ok ? MAGIC_ADDR : DATA_ADDR;

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error_code = error_reg;
  assign rom_valid  = rom_valid_reg;
  assign rom_data   = rom_data_reg;
  assign rom_index  = index_reg;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      pr_sel_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= ERR_NONE;
      rom_valid_reg <= 1'b0;
      rom_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            index_reg  <= '0;
            error_reg  <= ERR_NONE;
            pr_sel_reg <= pr_sel;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RD_MAGIC;
          end
        end
        ST_RD_MAGIC: begin
          if (up_rack) begin
            if (up_rresp != RESP_OKAY) begin
              error_reg <= ERR_RESP;
              state_reg <= ST_ERR;
            end else if (up_rdata != CORE_MAGIC) begin
              error_reg <= ERR_MAGIC;
              state_reg <= ST_ERR;
            end else begin
              state_reg <= ST_WR_ADDR;
            end
          end
        end
        ST_WR_ADDR: begin
          if (up_wack) begin
            if (up_wresp != RESP_OKAY) begin
              error_reg <= ERR_RESP;
              state_reg <= ST_ERR;
            end else begin
              state_reg <= ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (up_rack) begin
            if (up_rresp != RESP_OKAY) begin
              error_reg <= ERR_RESP;
              state_reg <= ST_ERR;
            end else begin
              rom_data_reg  <= up_rdata[ROM_WIDTH-1:0];
              rom_valid_reg <= 1'b1;
              state_reg     <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (stream_hs) begin
            rom_valid_reg <= 1'b0;
            if (index_reg == LAST_INDEX) begin
              done_reg  <= 1'b1;
              state_reg <= ST_FIN;
            end else begin
              index_reg <= index_reg + ONE_INDEX;
              state_reg <= ST_WR_ADDR;
            end
          end
        end
        ST_ERR: begin
          done_reg  <= 1'b1;
          state_reg <= ST_FIN;
        end
        ST_FIN: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  up_axi_master u_master (
    .clk           (m_axi_aclk),
    .rst_n         (m_axi_aresetn),
    .up_wreq       (up_wreq),
    .up_waddr      (ADDR_ADDR),
    .up_wdata      (up_wdata),
    .up_wack       (up_wack),
    .up_wresp      (up_wresp),
    .up_rreq       (up_rreq),
    .up_raddr      (up_raddr),
    .up_rack       (up_rack),
    .up_rdata      (up_rdata),
    .up_rresp      (up_rresp),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awready (m_axi_awready),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bready  (m_axi_bready),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rready  (m_axi_rready)
  );

endmodule

// File: tb/tb_axi_sysid_reader.sv
// Bench for axi_sysid_reader: an AXI4-Lite sys_id responder with configurable
// ready skew and error injection, and a scan-level reference model.
module tb_axi_sysid_reader;

  localparam logic [31:0] MAGIC = 32'h53594944;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pr_sel;
  logic        busy;
  logic        done;
  logic [1:0]  error_code;
  logic        rom_valid;
  logic        rom_ready;
  logic [31:0] rom_data;
  logic [5:0]  rom_index;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  axi_sysid_reader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(6), .BASE_ADDR(16'h0000)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .start(start), .pr_sel(pr_sel),
    .busy(busy), .done(done), .error_code(error_code),
    .rom_valid(rom_valid), .rom_ready(rom_ready), .rom_data(rom_data), .rom_index(rom_index),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rresp(m_axi_rresp), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder configuration, written only by the main sequence
  logic [31:0] rom_mem [64];
  logic [31:0] magic_val;
  bit          rerr_magic;
  int          berr_idx;
  int          aw_dly_cfg, w_dly_cfg;
  bit          rnd, rnd_ready, bp_mode;

  int vectors = 0;
  int miscompares = 0;

  // responder state
  int          aw_wait, w_wait, aw_dly_cur, w_dly_cur;
  logic        got_aw, got_w, ga, gw;
  logic [31:0] wd_hold, wd;
  logic [15:0] wa_hold, wa;
  logic [5:0]  rom_sel;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly_cur);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly_cur);
  assign m_axi_arready = m_axi_arvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; aw_wait <= 0; w_wait <= 0;
      aw_dly_cur <= 0; w_dly_cur <= 0; rom_sel <= '0;
      wd_hold <= '0; wa_hold <= '0;
    end else begin
      ga = got_aw || (m_axi_awvalid && m_axi_awready);
      gw = got_w || (m_axi_wvalid && m_axi_wready);
      wd = (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : wd_hold;
      wa = (m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : wa_hold;
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      if (!m_axi_awvalid) aw_dly_cur <= rnd ? int'($urandom_range(0, 3)) : aw_dly_cfg;
      if (!m_axi_wvalid)  w_dly_cur  <= rnd ? int'($urandom_range(0, 3)) : w_dly_cfg;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (ga && gw) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= (berr_idx >= 0 && int'(wd[5:0]) == berr_idx) ? 2'b10 : 2'b00;
        if (wa == 16'h0088) rom_sel <= wd[5:0];
      end else begin
        got_aw <= ga; got_w <= gw; wd_hold <= wd; wa_hold <= wa;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        if (m_axi_araddr == 16'h000C) begin
          m_axi_rdata <= magic_val; m_axi_rresp <= rerr_magic ? 2'b10 : 2'b00;
        end else if (m_axi_araddr == 16'h0084) begin
          m_axi_rdata <= rom_mem[rom_sel]; m_axi_rresp <= 2'b00;
        end else begin
          m_axi_rdata <= '0; m_axi_rresp <= 2'b10;
        end
      end
    end
  end

  // transaction logs
  logic [15:0] aw_q[$], ar_q[$];
  logic [31:0] w_q[$], wdat_q[$];
  logic [5:0]  widx_q[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_axi_awvalid && m_axi_awready) aw_q.push_back(m_axi_awaddr);
      if (m_axi_wvalid && m_axi_wready) w_q.push_back(m_axi_wdata);
      if (m_axi_arvalid && m_axi_arready) ar_q.push_back(m_axi_araddr);
      if (rom_valid && rom_ready) begin
        widx_q.push_back(rom_index);
        wdat_q.push_back(rom_data);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // stream ready: random, tied high, or held low for 10 valid cycles at index 7
  int bp_cnt;
  initial begin
    rom_ready = 1'b1;
    bp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) bp_cnt = 0;
      if (bp_mode && rom_index == 6'd7 && bp_cnt < 10) begin
        rom_ready = 1'b0;
        if (rom_valid) bp_cnt++;
      end else if (rnd_ready) begin
        rom_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rom_ready = 1'b1;
      end
    end
  end

  typedef struct {
    bit          pr;
    logic [31:0] magic;
    bit          rerr;
    int          berr;
    int          aw_dly;
    int          w_dly;
    bit          rnd;
    bit          bp;
    logic [1:0]  exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ctrl"}, 64'({busy, done, error_code, rom_valid, rom_index, m_axi_awvalid,
          m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_awprot, m_axi_arprot}), 64'd0);
    check({tag, " rom_data"}, 64'(rom_data), 64'd0);
    check({tag, " wdata"}, 64'(m_axi_wdata), 64'd0);
    check({tag, " addrs"}, 64'({m_axi_awaddr, m_axi_araddr}), 64'd0);
  endtask

  task automatic setup_cfg(input vec_t v);
    magic_val = v.magic; rerr_magic = v.rerr; berr_idx = v.berr;
    aw_dly_cfg = v.aw_dly; w_dly_cfg = v.w_dly;
    rnd = v.rnd; rnd_ready = v.rnd; bp_mode = v.bp;
    for (int i = 0; i < 64; i++) rom_mem[i] = v.rnd ? $urandom : 32'h01010101 * i;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int wb, ab, wdb, rb, db, cyc, stalls, n_wr, n_rd, bad;
    logic [31:0] exp_w;
    setup_cfg(v);
    wb = widx_q.size(); ab = aw_q.size(); wdb = w_q.size(); rb = ar_q.size(); db = done_cnt;
    @(negedge clk); start = 1'b1; pr_sel = v.pr;
    @(negedge clk); start = 1'b0; pr_sel = ~v.pr;
    check({tag, " busy/arvalid after start"}, 64'({busy, m_axi_arvalid}), 64'h3);
    cyc = 1; stalls = 0;
    while (!done && cyc < 3000) begin
      if (v.bp && rom_valid && !rom_ready) begin
        stalls++;
        check({tag, " stall rom_index"}, 64'(rom_index), 64'd7);
        check({tag, " stall rom_data"}, 64'(rom_data), 64'(rom_mem[7]));
        check({tag, " stall axi idle"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
              m_axi_bready, m_axi_rready}), 64'd0);
      end
      @(negedge clk); cyc++;
    end
    check({tag, " done seen"}, 64'(done), 64'd1);
    check({tag, " error_code"}, 64'(error_code), 64'(v.exp_err));
    if (!v.rnd && !v.bp && v.aw_dly == 0 && v.w_dly == 0 && v.exp_err == 2'd0)
      check({tag, " cycles within bound"}, 64'(cyc <= 8 * 64 + 4), 64'd1);
    @(negedge clk);
    check({tag, " busy/done after done"}, 64'({busy, done}), 64'd0);
    check({tag, " done pulses"}, 64'(done_cnt - db), 64'd1);
    // expected traffic from the scan rules
    if (v.magic != MAGIC || v.rerr) begin n_wr = 0; n_rd = 0; end
    else if (v.berr >= 0) begin n_wr = v.berr + 1; n_rd = v.berr; end
    else begin n_wr = 64; n_rd = 64; end
    check({tag, " word count"}, 64'(widx_q.size() - wb), 64'(v.exp_words));
    bad = 0;
    for (int k = 0; k < v.exp_words && wb + k < widx_q.size(); k++)
      if (widx_q[wb + k] !== 6'(k) || wdat_q[wb + k] !== rom_mem[k]) bad++;
    check({tag, " word index/data errors"}, 64'(bad), 64'd0);
    check({tag, " AW count"}, 64'(aw_q.size() - ab), 64'(n_wr));
    check({tag, " W count"}, 64'(w_q.size() - wdb), 64'(n_wr));
    bad = 0;
    for (int k = 0; k < n_wr && wdb + k < w_q.size() && ab + k < aw_q.size(); k++) begin
      exp_w = {v.pr, 25'd0, 6'(k)};
      if (w_q[wdb + k] !== exp_w || aw_q[ab + k] !== 16'h0088) bad++;
    end
    check({tag, " AW/W content errors"}, 64'(bad), 64'd0);
    check({tag, " AR count"}, 64'(ar_q.size() - rb), 64'(1 + n_rd));
    if (ar_q.size() > rb) check({tag, " first AR addr"}, 64'(ar_q[rb]), 64'h000C);
    bad = 0;
    for (int k = rb + 1; k < ar_q.size(); k++) if (ar_q[k] !== 16'h0084) bad++;
    check({tag, " data AR addr errors"}, 64'(bad), 64'd0);
    if (v.bp) check({tag, " stall cycles"}, 64'(stalls), 64'd10);
    $display("%s: err=%0d words=%0d cycles=%0d", tag, error_code, widx_q.size() - wb, cyc);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; pr_sel = 1'b0;
    setup_cfg('{1'b0, MAGIC, 1'b0, -1, 0, 0, 1'b0, 1'b0, 2'd0, 64});
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    //          pr    magic          rerr  berr aw w  rnd   bp    err   words
    vecs[0] = '{1'b0, MAGIC,         1'b0, -1,  0, 0, 1'b0, 1'b0, 2'd0, 64};
    vecs[1] = '{1'b0, 32'hDEADBEEF,  1'b0, -1,  0, 0, 1'b0, 1'b0, 2'd1, 0};
    vecs[2] = '{1'b0, MAGIC,         1'b0,  5,  0, 0, 1'b0, 1'b0, 2'd2, 5};
    vecs[3] = '{1'b1, MAGIC,         1'b0, -1,  0, 3, 1'b0, 1'b0, 2'd0, 64};
    vecs[4] = '{1'b1, MAGIC,         1'b0, -1,  0, 0, 1'b1, 1'b0, 2'd0, 64};
    vecs[5] = '{1'b0, MAGIC,         1'b0, 63,  0, 0, 1'b1, 1'b0, 2'd2, 63};
    vecs[6] = '{1'b0, MAGIC,         1'b1, -1,  0, 0, 1'b0, 1'b0, 2'd2, 0};
    vecs[7] = '{1'b0, MAGIC,         1'b0, -1,  0, 0, 1'b0, 1'b1, 2'd0, 64};
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset asserted while a data read address is outstanding
    setup_cfg(vecs[0]);
    @(negedge clk); start = 1'b1; pr_sel = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(m_axi_arvalid && rom_index >= 6'd3) && cyc < 500) begin
      @(negedge clk); cyc++;
    end
    check("mid-scan arvalid reached", 64'(m_axi_arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid-scan reset");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    $display("mid-scan reset applied at rom_index>=3");
    run_vec(vecs[0], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_sysid_reader.md
# axi_sysid_reader

AXI4-Lite master that walks the system-ID ROM exposed by the `sys_id` register map and delivers its contents to fabric logic.
- On `start` it reads the magic register and checks it against `SYID`.
- It then writes each ROM address to the address register and reads the data register, for every address from 0 to 2^ROM_ADDR_BITS-1.
- Each word is streamed out on a valid/ready port.
- It sits between an on-chip controller (boot FSM, soft CPU, or debug bridge) and the `sys_id` slave port on the same interconnect.

## Interface
Parameters:
- `ROM_WIDTH`, 32: width of the ROM word; must be ≤ 32.
- `ROM_ADDR_BITS`, 6: number of address bits; the ROM depth is 2^ROM_ADDR_BITS.
- `BASE_ADDR`, 16'h0000: byte base address of the `sys_id` register map.

Ports (each line: name, direction, width, meaning):
- `m_axi_aclk`, in, 1: the only clock.
- `m_axi_aresetn`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: one-cycle request to begin a scan.
- `pr_sel`, in, 1: sampled at `start`. 0 reads the system ROM, 1 reads the PR ROM. It is written to bit 31 of the address register.
- `busy`, out, 1: high from the accepted `start` until the cycle after `done`.
- `done`, out, 1: one-cycle pulse when the scan ends, on success or on error.
- `error_code`, out, 2: 0 = none, 1 = bad magic, 2 = non-OKAY response. Held until the next accepted `start`.
- `rom_valid`, out, 1: stream valid.
- `rom_ready`, in, 1: stream ready.
- `rom_data`, out, ROM_WIDTH: ROM word.
- `rom_index`, out, ROM_ADDR_BITS: address of `rom_data`.
- AXI4-Lite master write channels:
  - `m_axi_awvalid` out 1; `m_axi_awaddr` out 16; `m_axi_awprot` out 3 (always 0); `m_axi_awready` in 1.
  - `m_axi_wvalid` out 1; `m_axi_wdata` out 32; `m_axi_wstrb` out 4 (always 4'hf); `m_axi_wready` in 1.
  - `m_axi_bvalid` in 1; `m_axi_bresp` in 2; `m_axi_bready` out 1.
- AXI4-Lite master read channels:
  - `m_axi_arvalid` out 1; `m_axi_araddr` out 16; `m_axi_arprot` out 3 (always 0); `m_axi_arready` in 1.
  - `m_axi_rvalid` in 1; `m_axi_rresp` in 2; `m_axi_rdata` in 32; `m_axi_rready` out 1.

## Operation
States: IDLE → RD_MAGIC → WR_ADDR → RD_DATA → PUSH → (WR_ADDR | FIN); ERR → FIN; FIN → IDLE.
- **IDLE**:
  - `start` clears `index` and `error_code`, latches `pr_sel`, and moves to RD_MAGIC.
  - `start` in any other state is ignored.
- **RD_MAGIC**:
  - Issues AR to BASE_ADDR+0x0C.
  - When the read data is accepted:
    - non-OKAY `rresp` → `error_code`=2, go to ERR;
    - `rdata` ≠ 32'h53594944 → `error_code`=1, go to ERR;
    - otherwise → WR_ADDR.
- **WR_ADDR**:
  - Issues AW to BASE_ADDR+0x88 and W with `wdata` = {pr_sel, 31-ROM_ADDR_BITS zeros, index}.
  - `awvalid` and `wvalid` assert in the same cycle. Each drops independently after its own handshake.
  - `bready` asserts only once both handshakes have completed.
  - When B is accepted: non-OKAY `bresp` → `error_code`=2, go to ERR; otherwise → RD_DATA.
- **RD_DATA**:
  - Issues AR to BASE_ADDR+0x84.
  - When R is accepted: non-OKAY `rresp` → `error_code`=2, go to ERR; otherwise latch `rdata[ROM_WIDTH-1:0]` and go to PUSH.
- **PUSH**:
  - `rom_valid`=1 with `rom_data` and `rom_index`=index.
  - On `rom_valid && rom_ready`:
    - if index = 2^ROM_ADDR_BITS-1 → FIN;
    - else index+1 → WR_ADDR.
  - `index` never wraps within one scan.
- **ERR**: no AXI activity; goes to FIN on the next cycle.
- **FIN**: `done`=1 for one cycle, then IDLE.
- AXI rules:
  - A valid, once asserted, holds until its handshake completes; address and data stay stable meanwhile.
  - Only one transaction is outstanding at any time.
  - No request is abandoned once issued.

## Timing
- Reset values: all outputs 0, including every valid/ready, `busy`, `done`, `error_code`, `rom_*`, and all addresses and data. Reset is honoured in any state, immediately.
- `start` at edge N → `m_axi_arvalid`=1 and `busy`=1 at N+1.
- `m_axi_rready` and `m_axi_bready` are registered. They assert one cycle after entering the wait phase and deassert in the cycle following the handshake.
- `rom_valid` asserts the cycle after R is accepted.
- The next AW/W issues the cycle after the stream handshake.
- With a zero-wait slave and `rom_ready` tied high: ≤ 8 cycles per ROM word; `done` at most 8×2^ROM_ADDR_BITS+4 cycles after `start`.
- Under stream backpressure, `rom_data`/`rom_index` are stable and no AXI channel is active.
- `done` and `busy` fall together; `busy` is 0 in the cycle after `done`.

## Structure
- Package `sysid_pkg` holds:
  - register word offsets: VERSION 0x00, ID 0x01, SCRATCH 0x02, MAGIC 0x03, ROM_DATA 0x21, ROM_ADDR 0x22;
  - `CORE_MAGIC` 32'h53594944;
  - the error-code constants;
  - the state enumeration.
- Sub-module `up_axi_master`: single-transaction engine taking an up-style request (`up_wreq`/`up_waddr`/`up_wdata` → `up_wack` + `up_wresp`; `up_rreq`/`up_raddr` → `up_rack` + `up_rdata` + `up_rresp`) and driving the five AXI4-Lite channels. The top level holds the scan FSM and the stream register.

## Test plan
- **Clean scan.** Responder returns magic 0x53594944 and ROM[i] = 0x01010101·i; `start` with `pr_sel`=0, `rom_ready`=1 → 64 words, index 0..63, data matches; `done` once; `error_code`=0; every W has `wdata[31]`=0.
- **Bad magic.** Magic read returns 0xDEADBEEF → no AW/W issued; `error_code`=1; `done` pulses; `busy` falls the next cycle.
- **Write error.** `bresp`=SLVERR on the write for index 5 → words 0–4 delivered; no AR to 0x84 for index 5; `error_code`=2.
- **Channel skew and PR select.** `awready` 3 cycles before `wready`, `pr_sel`=1 → exactly one AW and one W per word; `wdata` = 0x80000000 | index.
- **Backpressure.** `rom_ready` low for 10 cycles at index 7 → `rom_data`/`rom_index` held; no valid on any AXI channel; scan resumes at index 8.
- **Reset mid-scan.** `m_axi_aresetn` asserted while `m_axi_arvalid`=1 → all outputs 0 in the same cycle; a later `start` restarts from the magic read.
